// File: rtl/lif_neuron.sv
// lif_neuron: leaky integrate-and-fire neuron with a small config register file.
//
// Incoming per-channel currents are summed into a signed membrane potential.
// A periodic leak tick subtracts membrane >>> leak_shift. When the saturated
// membrane reaches v_threshold the neuron fires a one-cycle spike, reloads
// v_reset and optionally sits out a refractory period.
//
// Ports:
//   clk          - single clock
//   reset        - asynchronous active-low reset
//   in_valid     - per-channel input spike valid
//   in_current   - packed signed per-channel currents, channel i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   cfg_we       - config write strobe
//   cfg_addr     - 0 v_threshold, 1 v_reset, 2 taumem_scale, 3 tauref_cycles,
//                  4 leak_shift, 5 enable; other addresses ignored
//   cfg_wdata    - config write data (low bits used for narrow registers)
//   spike_out    - one-cycle spike pulse
//   membrane_out - signed membrane value
//   refractory   - high while in REFRACTORY
//   spike_count  - wrapping count of emitted spikes
//
// state      | meaning
// IDLE       | disabled, membrane held at v_reset, timers cleared
// INTEGRATE  | accumulating inputs, leak timer running, threshold compare
// REFRACTORY | post-spike dead time, inputs and leak ignored

module lif_neuron #(
    parameter int N_INPUTS       = 4,
    parameter int WEIGHT_WIDTH   = 6,
    parameter int MEMBRANE_WIDTH = 16,
    parameter int COUNTER_WIDTH  = 8,
    parameter logic signed [MEMBRANE_WIDTH-1:0] V_THRESHOLD_DEF = 16'h1000,
    parameter logic signed [MEMBRANE_WIDTH-1:0] V_RESET_DEF     = '0,
    parameter logic [COUNTER_WIDTH-1:0]         TAUMEM_DEF      = 8'h10,
    parameter logic [COUNTER_WIDTH-1:0]         TAUREF_DEF      = 8'h10,
    parameter logic [3:0]                       LEAK_SHIFT_DEF  = 4'd1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_INPUTS-1:0]              in_valid,
    input  logic [N_INPUTS*WEIGHT_WIDTH-1:0] in_current,
    input  logic                             cfg_we,
    input  logic [2:0]                       cfg_addr,
    input  logic [MEMBRANE_WIDTH-1:0]        cfg_wdata,
    output logic                             spike_out,
    output logic [MEMBRANE_WIDTH-1:0]        membrane_out,
    output logic                             refractory,
    output logic [COUNTER_WIDTH-1:0]         spike_count
);

    // Sum width holds N_INPUTS full-membrane-width terms without overflow;
    // one extra bit on top covers membrane - leak + sum.
    localparam int SUM_W  = MEMBRANE_WIDTH + $clog2(N_INPUTS) + 1;
    localparam int NEXT_W = SUM_W + 1;

    localparam logic signed [MEMBRANE_WIDTH-1:0] MEM_MAX = {1'b0, {(MEMBRANE_WIDTH-1){1'b1}}};
    localparam logic signed [MEMBRANE_WIDTH-1:0] MEM_MIN = {1'b1, {(MEMBRANE_WIDTH-1){1'b0}}};
    localparam logic [COUNTER_WIDTH-1:0]         CNT_ONE = COUNTER_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        INTEGRATE  = 2'd1,
        REFRACTORY = 2'd2
    } state_t;

    state_t state;

    logic signed [MEMBRANE_WIDTH-1:0] v_threshold;
    logic signed [MEMBRANE_WIDTH-1:0] v_reset;
    logic [COUNTER_WIDTH-1:0]         taumem_scale;
    logic [COUNTER_WIDTH-1:0]         tauref_cycles;
    logic [3:0]                       leak_shift;
    logic                             enable;

    logic signed [MEMBRANE_WIDTH-1:0] membrane;
    logic [COUNTER_WIDTH-1:0]         leak_timer;
    logic [COUNTER_WIDTH-1:0]         ref_timer;

    logic signed [WEIGHT_WIDTH-1:0]   chan [N_INPUTS];
    logic signed [SUM_W-1:0]          in_sum;
    logic                             tick;
    logic signed [MEMBRANE_WIDTH-1:0] leak;
    logic signed [NEXT_W-1:0]         next_raw;
    logic signed [MEMBRANE_WIDTH-1:0] next_sat;
    logic                             crossing;

    for (genvar g = 0; g < N_INPUTS; g++) begin : g_chan
        assign chan[g] = in_current[g*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end

    always_comb begin
        in_sum = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (in_valid[i]) begin
                in_sum = in_sum + SUM_W'(chan[i]);
            end
        end
    end

    // >= rather than == so that lowering taumem_scale below the running
    // count still produces a tick instead of waiting for a wrap.
    assign tick = (leak_timer >= taumem_scale);
    assign leak = (tick && leak_shift != 4'd0) ? (membrane >>> leak_shift) : '0;

    always_comb begin
        next_raw = NEXT_W'(membrane) - NEXT_W'(leak) + NEXT_W'(in_sum);
        if (next_raw > NEXT_W'(MEM_MAX)) begin
            next_sat = MEM_MAX;
        end else if (next_raw < NEXT_W'(MEM_MIN)) begin
            next_sat = MEM_MIN;
        end else begin
            next_sat = next_raw[MEMBRANE_WIDTH-1:0];
        end
    end

    assign crossing = (next_sat >= v_threshold);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_threshold   <= V_THRESHOLD_DEF;
            v_reset       <= V_RESET_DEF;
            taumem_scale  <= TAUMEM_DEF;
            tauref_cycles <= TAUREF_DEF;
            leak_shift    <= LEAK_SHIFT_DEF;
            enable        <= 1'b1;
        end else if (cfg_we) begin
            case (cfg_addr)
                3'd0:    v_threshold   <= cfg_wdata;
                3'd1:    v_reset       <= cfg_wdata;
                3'd2:    taumem_scale  <= cfg_wdata[COUNTER_WIDTH-1:0];
                3'd3:    tauref_cycles <= cfg_wdata[COUNTER_WIDTH-1:0];
                3'd4:    leak_shift    <= cfg_wdata[3:0];
                3'd5:    enable        <= cfg_wdata[0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= INTEGRATE;
            membrane    <= V_RESET_DEF;
            spike_out   <= 1'b0;
            refractory  <= 1'b0;
            spike_count <= '0;
            leak_timer  <= '0;
            ref_timer   <= '0;
        end else begin
            spike_out <= 1'b0;
            if (!enable) begin
                state      <= IDLE;
                membrane   <= v_reset;
                refractory <= 1'b0;
                leak_timer <= '0;
                ref_timer  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state      <= INTEGRATE;
                        membrane   <= v_reset;
                        leak_timer <= '0;
                    end
                    INTEGRATE: begin
                        leak_timer <= tick ? '0 : leak_timer + CNT_ONE;
                        if (crossing) begin
                            membrane    <= v_reset;
                            spike_out   <= 1'b1;
                            spike_count <= spike_count + CNT_ONE;
                            if (tauref_cycles != '0) begin
                                state      <= REFRACTORY;
                                refractory <= 1'b1;
                                // Down-counter reaches zero on the last refractory cycle.
                                ref_timer  <= tauref_cycles - CNT_ONE;
                                leak_timer <= '0;
                            end
                        end else begin
                            membrane <= next_sat;
                        end
                    end
                    REFRACTORY: begin
                        membrane <= v_reset;
                        if (ref_timer == '0) begin
                            state      <= INTEGRATE;
                            refractory <= 1'b0;
                            leak_timer <= '0;
                        end else begin
                            ref_timer <= ref_timer - CNT_ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign membrane_out = membrane;

endmodule

// File: tb/tb_lif_neuron.sv
// Directed testbench for lif_neuron with hand-computed expected values.
module tb_lif_neuron;

    logic        clk;
    logic        reset;
    logic [3:0]  in_valid;
    logic [23:0] in_current;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        spike_out;
    logic [15:0] membrane_out;
    logic        refractory;
    logic [7:0]  spike_count;

    int n_total = 0;
    int n_pass  = 0;

    lif_neuron dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_current   (in_current),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .spike_out    (spike_out),
        .membrane_out (membrane_out),
        .refractory   (refractory),
        .spike_count  (spike_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic [15:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = '0;
        in_current = '0;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_wdata  = '0;

        // Reset values
        #12;
        check("rst_mem",   $signed(membrane_out), 0);
        check("rst_spike", spike_out, 0);
        check("rst_refr",  refractory, 0);
        check("rst_count", spike_count, 0);
        reset = 1'b1;

        // Threshold, no refractory
        cfg_write(3'd0, 16'd100);
        cfg_write(3'd4, 16'd0);
        cfg_write(3'd3, 16'd0);
        in_valid   = 4'b0001;
        in_current = 24'd20;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("thr_mem", $signed(membrane_out), 20 * k);
            check("thr_nospike", spike_out, 0);
        end
        step();
        check("thr_spike1",     spike_out, 1);
        check("thr_spike1_mem", $signed(membrane_out), 0);
        check("thr_count1",     spike_count, 1);
        for (int k = 1; k <= 4; k++) begin
            step();
            check("thr_mem2", $signed(membrane_out), 20 * k);
        end
        step();
        check("thr_spike2", spike_out, 1);
        check("thr_count2", spike_count, 2);
        step();
        check("thr_pulse_end", spike_out, 0);
        check("thr_resume",    $signed(membrane_out), 20);

        // Enable off: inputs ignored, membrane held at v_reset
        cfg_write(3'd5, 16'd0);
        check("en_last_int", $signed(membrane_out), 40);
        step();
        check("en_idle_mem", $signed(membrane_out), 0);
        step();
        step();
        check("en_ignore_in", $signed(membrane_out), 0);
        check("en_nospike",   spike_out, 0);
        cfg_write(3'd5, 16'd1);
        check("en_still_idle", $signed(membrane_out), 0);
        step();
        check("en_enter_int", $signed(membrane_out), 0);
        step();
        check("en_integrate", $signed(membrane_out), 20);

        // Refractory of 3 cycles
        in_valid = 4'b0000;
        cfg_write(3'd3, 16'd3);
        cfg_write(3'd5, 16'd0);
        step();
        cfg_write(3'd5, 16'd1);
        step();
        check("ref_start_mem", $signed(membrane_out), 0);
        in_valid = 4'b0001;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("ref_mem_a", $signed(membrane_out), 20 * k);
        end
        step();
        check("ref_spike1", spike_out, 1);
        check("ref_refr1",  refractory, 1);
        check("ref_mem0",   $signed(membrane_out), 0);
        for (int k = 0; k < 2; k++) begin
            step();
            check("ref_refr_hold",  refractory, 1);
            check("ref_nospike",    spike_out, 0);
            check("ref_mem_hold",   $signed(membrane_out), 0);
        end
        step();
        check("ref_exit",     refractory, 0);
        check("ref_exit_mem", $signed(membrane_out), 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check("ref_mem_b", $signed(membrane_out), 20 * k);
        end
        step();
        check("ref_spike2", spike_out, 1);
        check("ref_count",  spike_count, 4);

        // Leak: preload 64 through v_reset while disabled
        in_valid = 4'b0000;
        cfg_write(3'd5, 16'd0);
        cfg_write(3'd1, 16'd64);
        cfg_write(3'd4, 16'd2);
        cfg_write(3'd2, 16'd3);
        cfg_write(3'd5, 16'd1);
        step();
        check("leak_pre", $signed(membrane_out), 64);
        step();
        step();
        step();
        check("leak_hold", $signed(membrane_out), 64);
        step();
        check("leak_48", $signed(membrane_out), 48);
        repeat (4) step();
        check("leak_36", $signed(membrane_out), 36);
        repeat (4) step();
        check("leak_27", $signed(membrane_out), 27);

        // Negative saturation
        cfg_write(3'd4, 16'd0);
        cfg_write(3'd5, 16'd0);
        cfg_write(3'd1, 16'h8008);
        cfg_write(3'd5, 16'd1);
        step();
        check("sat_pre", $signed(membrane_out), -32760);
        in_valid   = 4'b1111;
        in_current = {4{6'b100000}};
        step();
        check("sat_min", $signed(membrane_out), -32768);
        step();
        check("sat_min_hold", $signed(membrane_out), -32768);
        in_valid   = 4'b0011;
        in_current = {6'd0, 6'd0, 6'b100000, 6'd31};
        step();
        check("sat_net_neg1", $signed(membrane_out), -32768);
        check("sat_nospike",  spike_out, 0);

        // Asynchronous reset in the middle of a refractory period
        in_valid = 4'b0000;
        cfg_write(3'd1, 16'd50);
        cfg_write(3'd0, 16'd10);
        cfg_write(3'd3, 16'd20);
        cfg_write(3'd5, 16'd0);
        step();
        cfg_write(3'd5, 16'd1);
        step();
        check("ar_pre_mem", $signed(membrane_out), 50);
        in_valid   = 4'b0001;
        in_current = 24'd1;
        step();
        check("ar_spike", spike_out, 1);
        check("ar_count", spike_count, 5);
        step();
        check("ar_refr",     refractory, 1);
        check("ar_refr_mem", $signed(membrane_out), 50);
        #2;
        reset = 1'b0;
        #1;
        check("ar_mem",   $signed(membrane_out), 0);
        check("ar_refr0", refractory, 0);
        check("ar_spike0", spike_out, 0);
        check("ar_count0", spike_count, 0);
        #2;
        reset = 1'b1;
        step();
        check("ar_post_int", $signed(membrane_out), 1);
        check("ar_post_refr", refractory, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
